regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Parametrised multi-read-port register file for the MIPS datapath; next generation of the 32x32 two-read file.
// - Generalises data width, depth and read-port count; adds hardwired zero register and a sequential clear sweep after reset.
// - Sits between decode (read addresses) and writeback (write port); busy gates the pipeline until the clear sweep completes.
// PARAMETERS
// - DATA_W    32  bits per register
// - ADDR_W    5   address bits; DEPTH = 2**ADDR_W entries
// - NREAD     2   number of independent asynchronous read ports (1..4)
// - ZERO_REG  1   1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
// - clk    in   1               single clock; all state updates on posedge
// - rst    in   1               synchronous, active-high reset
// - RegWr  in   1               write enable
// - Rw     in   ADDR_W          write address
// - busW   in   DATA_W          write data
// - Ra     in   NREAD*ADDR_W    read addresses, port k = Ra[k*ADDR_W +: ADDR_W]
// - busA   out  NREAD*DATA_W    read data, port k = busA[k*DATA_W +: DATA_W]
// - busy   out  1               1 while clear sweep in progress
// BEHAVIOUR
// - Single clock, synchronous active-high reset; no other clock or reset.
// - FSM states CLEAR, READY. rst=1 at posedge -> state=CLEAR, cnt=0 (overrides everything, incl. mid-sweep).
// - CLEAR: each posedge writes 0 to entry cnt, cnt++; at cnt==DEPTH-1 entry is cleared and state -> READY.
// - Sweep length: DEPTH cycles after the first posedge with rst=0; busy=1 throughout, 0 from the edge entering READY.
// - Reset value: busy=1; busA=0 on all ports while busy.
// - Writes: READY and RegWr=1 -> entry Rw <= busW at posedge. Writes while busy are dropped (not queued).
// - ZERO_REG=1: write to Rw=0 dropped; read of address 0 returns 0 regardless of storage.
// - Reads: combinational, zero latency, all ports independent; same address on multiple ports allowed.
// - Read of Rw in the cycle of its write returns the old value unless bypass is compiled in (below).
// - cnt is ADDR_W bits; no wrap beyond DEPTH-1 since state leaves CLEAR at that count.
// - No initial blocks: contents are defined only by the clear sweep.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
// - Defined: if READY, RegWr=1, Ra[k]==Rw (and not zero reg when ZERO_REG=1), port k returns busW in the same cycle.
// - Undefined: no forwarding; port k returns stored value, new value visible the cycle after the write edge.
// STRUCTURE
// - Package regfile_pkg: state enum (CLEAR, READY), default DATA_W/ADDR_W/NREAD constants.
// - Sub-module regfile_clear_fsm: owns state, cnt, busy; outputs clr_we and clr_addr to the storage array.
// - Top: storage array, write mux (clear vs. RegWr), NREAD read muxes via generate, optional bypass.
// TESTING
// - Reset: rst=1 two cycles then 0 -> busy=1 for exactly 32 cycles (DEPTH=32), busA=0; then all 32 entries read 0.
// - Write/read: write 0xDEADBEEF to r5, 0x12345678 to r31 -> next cycle Ra0=5, Ra1=31 return both values.
// - Zero reg: write 0xFFFFFFFF to r0 -> read r0 returns 0 (ZERO_REG=1); with ZERO_REG=0 returns 0xFFFFFFFF.
// - Busy drop: RegWr=1, Rw=7, busW=0xA5A5A5A5 during sweep -> after READY, r7 reads 0.
// - Mid-sweep reset: rst pulse at sweep cycle 10 after writing nothing -> sweep restarts, busy stays 1 for 32 more cycles.
// - Bypass: write 0x0000CAFE to r3 with Ra0=3 same cycle -> busA0=0x0000CAFE with REGFILE_BYPASS_EN, old value without.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

  // Clear-sweep controller states
  typedef enum logic [0:0] {
    StClear = 1'b0,
    StReady = 1'b1
  } clr_state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNread = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: one write port, NREAD read ports, busy.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NREAD  = DefNread
);

  logic                    RegWr;
  logic [ADDR_W-1:0]       Rw;
  logic [DATA_W-1:0]       busW;
  logic [NREAD*ADDR_W-1:0] Ra;
  logic [NREAD*DATA_W-1:0] busA;
  logic                    busy;

  modport master (
    output RegWr, Rw, busW, Ra,
    input  busA, busy
  );

  modport slave (
    input  RegWr, Rw, busW, Ra,
    output busA, busy
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sweep: walks every entry once, writing zero, then releases busy.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter; reset restarts the sweep even mid-way
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, clear-port drive and busy
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_o   = 1'b0;
    clr_we_o = 1'b0;
    unique case (state_q)
      StClear: begin
        busy_o   = 1'b1;
        // Held off while rst is asserted so reset cycles leave storage untouched
        clr_we_o = ~rst;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          state_d = StReady;
          cnt_d   = '0;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero register and
// post-reset clear sweep. Compile with REGFILE_BYPASS_EN defined to forward the
// write data to any read port addressing the entry being written in the same cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NREAD    = DefNread,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_we;
  logic              wr_zero;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       rd_data [NREAD];
  logic [NREAD*DATA_W-1:0] busa_all;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // Writes to the hardwired zero entry are discarded
  assign wr_zero = ZeroEn && (bus.Rw == '0);
  assign usr_we  = ~busy & ~rst & bus.RegWr & ~wr_zero;

  // Storage: the clear sweep owns the write port until it finishes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (usr_we) begin
      mem_q[bus.Rw] <= bus.busW;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  // Not gated by rst: forwarding tracks the write request seen in the READY state
  assign byp_en = ~busy & bus.RegWr & ~wr_zero;
`endif

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.Ra[k*ADDR_W +: ADDR_W];

    // Read mux for port k: busy and zero-register masking, optional forwarding
    always_comb begin
      rd_data[k] = mem_q[ra];
      if (busy || (ZeroEn && (ra == '0))) begin
        rd_data[k] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (byp_en && (ra == bus.Rw)) begin
        rd_data[k] = bus.busW;
`endif
      end
    end
  end

  // Pack the per-port results onto the flat read bus
  always_comb begin
    busa_all = '0;
    for (int k = 0; k < NREAD; k++) begin
      busa_all[k*DATA_W +: DATA_W] = rd_data[k];
    end
  end

  assign bus.busA = busa_all;
  assign bus.busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp; two instances (ZERO_REG=1 and 0) share inputs.
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus2 ();

  assign bus2.RegWr = bus.RegWr;
  assign bus2.Rw    = bus.Rw;
  assign bus2.busW  = bus.busW;
  assign bus2.Ra    = bus.Ra;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  // ---------------- behavioural model ----------------
  // left: sweep cycles still to go (0 = ready). mem holds every accepted write,
  // including r0; the ZERO_REG=1 view masks r0 on read.
  int          left = 0;
  logic [31:0] mem [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      left <= DEPTH;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end
    end else if (bus.RegWr) begin
      mem[bus.Rw] <= bus.busW;
    end
  end

  function automatic logic [31:0] model_rd(int port, bit zr);
    logic [4:0] a;
    a = bus.Ra[port*AW +: AW];
    if (left > 0) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWr && bus.Rw == a) return bus.busW;
`endif
    return mem[a];
  endfunction

  // ---------------- comparison ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Directed expectations posted by the stimulus, consumed by the compare process
  int          pin_seq = 0;
  int          pin_done = 0;
  int          pin_dut = 0;
  int          pin_port = 0;
  logic [31:0] pin_exp = 0;
  logic [31:0] pin_ext = 0;
  string       pin_name = "";

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, bus.busy}, {31'b0, left > 0});
      chk("busy_nz", {31'b0, bus2.busy}, {31'b0, left > 0});
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("busA%0d", k), bus.busA[k*DW +: DW], model_rd(k, 1'b1));
        chk($sformatf("busA%0d_nz", k), bus2.busA[k*DW +: DW], model_rd(k, 1'b0));
      end
      if (pin_seq != pin_done) begin
        pin_done = pin_seq;
        if (pin_dut == 0) chk(pin_name, bus.busA[pin_port*DW +: DW], pin_exp);
        else if (pin_dut == 1) chk(pin_name, bus2.busA[pin_port*DW +: DW], pin_exp);
        else chk(pin_name, pin_ext, pin_exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(int p, logic [4:0] a);
    bus.Ra[p*AW +: AW] = a;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    bus.RegWr = 1'b1;
    bus.Rw    = a;
    bus.busW  = d;
    tick();
    bus.RegWr = 1'b0;
  endtask

  // Post a literal expectation checked at the next falling edge, then advance a cycle
  task automatic pin(string name, int d, int p, logic [31:0] exp, logic [31:0] ext);
    pin_name = name;
    pin_dut  = d;
    pin_port = p;
    pin_exp  = exp;
    pin_ext  = ext;
    pin_seq++;
    tick();
  endtask

  // Count falling edges with busy high; optionally stop a pending write after drop_n cycles
  task automatic count_busy(int drop_n, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
      if (n == drop_n) bus.RegWr = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.RegWr = 1'b0;
    bus.Rw    = '0;
    bus.busW  = '0;
    bus.Ra    = '0;
    rst       = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Sweep length, with a write to r7 attempted during the sweep
    bus.RegWr = 1'b1;
    bus.Rw    = 5'd7;
    bus.busW  = 32'hA5A5_A5A5;
    count_busy(5, n);
    pin("sweep_len", 2, 0, 32'd32, 32'(n));

    set_ra(0, 5'd7);
    pin("busy_drop_r7", 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      set_ra(0, 5'(i));
      set_ra(1, 5'(DEPTH - 1 - i));
      pin($sformatf("clr_r%0d", i), 1, 0, 32'h0, 32'h0);
    end

    // Basic write then read on two ports
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    set_ra(0, 5'd5);
    set_ra(1, 5'd31);
    pin("rd_r5", 0, 0, 32'hDEAD_BEEF, 32'h0);
    pin("rd_r31", 0, 1, 32'h1234_5678, 32'h0);

    // Zero register
    wr(5'd0, 32'hFFFF_FFFF);
    set_ra(0, 5'd0);
    set_ra(1, 5'd0);
    pin("zero_reg1", 0, 0, 32'h0, 32'h0);
    pin("zero_reg0", 1, 1, 32'hFFFF_FFFF, 32'h0);

    // Same-cycle read of the entry being written
    wr(5'd3, 32'h0000_1111);
    bus.RegWr = 1'b1;
    bus.Rw    = 5'd3;
    bus.busW  = 32'h0000_CAFE;
    set_ra(0, 5'd3);
`ifdef REGFILE_BYPASS_EN
    pin("bypass_same", 0, 0, 32'h0000_CAFE, 32'h0);
`else
    pin("bypass_same", 0, 0, 32'h0000_1111, 32'h0);
`endif
    bus.RegWr = 1'b0;
    pin("bypass_next", 0, 0, 32'h0000_CAFE, 32'h0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus.RegWr = 1'($urandom);
      bus.Rw    = 5'($urandom);
      bus.busW  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      bus.Ra    = 10'($urandom);
      if ($urandom_range(0, 3) == 0) set_ra(0, bus.Rw);
      if ($urandom_range(0, 7) == 0) set_ra(1, bus.Rw);
      tick();
    end
    rst       = 1'b0;
    bus.RegWr = 1'b0;

    // Reset in the middle of a sweep restarts it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(-1, n);
    pin("midsweep_len", 2, 0, 32'd32, 32'(n));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
